// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit -- instruction-fetch stage of the RV32I multi-cycle core.
//
// Holds the PC, fetches one word at a time from instruction memory over a
// req/ack handshake, and presents the registered word (with its PC and opcode
// field) to decode/control until downstream consumes it. PC redirects from the
// execute path take priority over everything else; a redirect that arrives
// while a fetch is outstanding lets that fetch finish (address held stable)
// and throws its data away.
//
// Optional feature macro: FETCH_MISALIGN_CHECK_EN
//   defined   : redirect targets are forced word-aligned and misalign_err
//               pulses for one cycle after a misaligned redirect.
//   undefined : targets are used as given and misalign_err is tied low.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous, active-low reset
//   imem_req     out  fetch request (high in FETCH/FLUSH)
//   imem_addr    out  fetch address, stable until acknowledged
//   imem_ack     in   memory returns imem_rdata this cycle
//   imem_rdata   in   instruction word
//   stall        in   downstream not ready (looked at only while holding a word)
//   redirect_en  in   one-cycle PC redirect request
//   redirect_pc  in   redirect target
//   instr        out  registered instruction word
//   instr_pc     out  address of instr
//   opcode       out  instr[6:0]
//   instr_valid  out  instr/instr_pc/opcode are valid
//   misalign_err out  misaligned-redirect pulse
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ack,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             stall,
  input  logic             redirect_en,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  output logic [6:0]       opcode,
  output logic             instr_valid,
  output logic             misalign_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,  // request outstanding, data will be kept
    VALID = 2'd2,  // holding a word for downstream
    FLUSH = 2'd3   // request outstanding, data is stale and will be dropped
  } state_e;

  localparam logic [WIDTH-1:0] INSTR_BYTES = WIDTH'(4);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] instr_pc_q, instr_pc_d;
  logic             instr_valid_q, instr_valid_d;
  logic [WIDTH-1:0] redirect_tgt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign redirect_tgt = {redirect_pc[WIDTH-1:2], 2'b00};
  assign misalign_d   = redirect_en && (redirect_pc[1:0] != 2'b00);
  assign misalign_err = misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) misalign_q <= 1'b0;
    else      misalign_q <= misalign_d;
  end
`else
  assign redirect_tgt = redirect_pc;
  assign misalign_err = 1'b0;
`endif

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned (which would infer a latch).
    state_d       = state_q;
    pc_d          = pc_q;
    req_addr_d    = req_addr_q;
    instr_d       = instr_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    unique case (state_q)
      IDLE: begin
        if (redirect_en) begin
          pc_d       = redirect_tgt;
          req_addr_d = redirect_tgt;
        end
        state_d = FETCH;
      end

      FETCH: begin
        if (redirect_en) begin
          pc_d = redirect_tgt;
          // With ack the bus is free, so the target can be requested at once;
          // without ack the old address must stay up until memory answers.
          if (imem_ack) req_addr_d = redirect_tgt;
          else          state_d    = FLUSH;
        end else if (imem_ack) begin
          instr_d       = imem_rdata;
          instr_pc_d    = req_addr_q;
          instr_valid_d = 1'b1;
          pc_d          = req_addr_q + INSTR_BYTES;
          state_d       = VALID;
        end
      end

      FLUSH: begin
        if (redirect_en) pc_d = redirect_tgt;
        if (imem_ack) begin
          // Same-cycle redirect must win over the pc_q it is overwriting.
          req_addr_d = redirect_en ? redirect_tgt : pc_q;
          state_d    = FETCH;
        end
      end

      VALID: begin
        if (redirect_en) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_tgt;
          req_addr_d    = redirect_tgt;
          state_d       = FETCH;
        end else if (!stall) begin
          instr_valid_d = 1'b0;
          req_addr_d    = pc_q;
          state_d       = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      req_addr_q    <= RESET_PC;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      pc_q          <= pc_d;
      req_addr_q    <= req_addr_d;
      instr_q       <= instr_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  assign imem_req    = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr   = req_addr_q;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign opcode      = instr_q[6:0];
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit -- scoreboard bench for fetch_unit.
//
// A small instruction-memory model answers requests after mem_lat wait cycles
// with a word derived from the address. Directed stimulus pushes the addresses
// it expects memory to acknowledge and the instructions it expects to see
// presented; a monitor pops and compares them as the DUT produces them.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ack;
  logic [W-1:0] imem_rdata;
  logic         stall;
  logic         redirect_en;
  logic [W-1:0] redirect_pc;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;
  logic [6:0]   opcode;
  logic         instr_valid;
  logic         misalign_err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [W-1:0] word;
    logic [W-1:0] pc;
  } instr_t;

  logic [W-1:0] ack_q[$];
  instr_t       instr_q[$];

  fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .stall        (stall),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .opcode       (opcode),
    .instr_valid  (instr_valid),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  // Memory contents: address 0 holds 32'h0000_0013 (addi x0,x0,0).
  function automatic logic [W-1:0] mem_word(input logic [W-1:0] a);
    return {a[24:0], a[8:2] ^ 7'h13};
  endfunction

  // Memory model: ack after mem_lat wait cycles of a continuous request.
  int mem_lat = 0;
  int wait_cnt = 0;
  assign imem_ack   = imem_req && (wait_cnt == mem_lat);
  assign imem_rdata = mem_word(imem_addr);

  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic instr_t exp_instr(input logic [W-1:0] a);
    instr_t e;
    e.word = mem_word(a);
    e.pc   = a;
    return e;
  endfunction

  // Monitor: compares every accepted request and every newly presented word.
  logic prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      if (imem_req && imem_ack) begin
        if (ack_q.size() == 0) check("unexpected_ack_addr", imem_addr, 'x);
        else                   check("ack_addr", imem_addr, ack_q.pop_front());
      end
      if (instr_valid && !prev_valid) begin
        if (instr_q.size() == 0) begin
          check("unexpected_instr_pc", instr_pc, 'x);
        end else begin
          instr_t e;
          e = instr_q.pop_front();
          check("instr", instr, e.word);
          check("instr_pc", instr_pc, e.pc);
          check("opcode", W'(opcode), W'(e.word[6:0]));
        end
      end
    end
    prev_valid = instr_valid;
  end

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!instr_valid && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid_timeout"}, W'(instr_valid), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [W-1:0] mis_tgt;
  logic         mis_exp;

  initial begin
    rst         = 1'b0;
    stall       = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = '0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_imem_req", W'(imem_req), 0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_instr_valid", W'(instr_valid), 0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_misalign", W'(misalign_err), 0);

    // ---- first fetch at 0, zero-wait memory ----
    ack_q.push_back(32'h0);
    instr_q.push_back(exp_instr(32'h0));
    rst = 1'b1;
    @(negedge clk);
    check("c1_imem_req", W'(imem_req), 1);
    check("c1_imem_addr", imem_addr, 32'h0);
    @(negedge clk);
    check("c2_instr_valid", W'(instr_valid), 1);
    check("c2_opcode", W'(opcode), 32'h13);
    check("c2_imem_req", W'(imem_req), 0);

    // ---- stall holds the word for 3 cycles ----
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", W'(instr_valid), 1);
      check("stall_instr", instr, 32'h0000_0013);
      check("stall_instr_pc", instr_pc, 32'h0);
      check("stall_no_req", W'(imem_req), 0);
    end
    stall = 1'b0;
    ack_q.push_back(32'h4);
    instr_q.push_back(exp_instr(32'h4));
    @(negedge clk);
    check("release_imem_req", W'(imem_req), 1);
    check("release_imem_addr", imem_addr, 32'h4);
    stall = 1'b1;
    @(negedge clk);
    check("v4_instr_pc", instr_pc, 32'h4);

    // ---- redirect in FETCH while memory takes 3 wait cycles ----
    mem_lat = 3;
    stall   = 1'b0;
    ack_q.push_back(32'h8);
    ack_q.push_back(32'h100);
    instr_q.push_back(exp_instr(32'h100));
    @(negedge clk);
    check("fl_req_addr", imem_addr, 32'h8);
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_en = 1'b0;
    begin
      int n = 0;
      while (!imem_ack && n < 10) begin
        check("fl_hold_addr", imem_addr, 32'h8);
        check("fl_hold_req", W'(imem_req), 1);
        check("fl_no_valid", W'(instr_valid), 0);
        @(negedge clk);
        n++;
      end
      check("fl_ack_timeout", W'(imem_ack), 1);
    end
    @(negedge clk);
    check("fl_new_addr", imem_addr, 32'h100);
    check("fl_stale_dropped", W'(instr_valid), 0);
    wait_valid("fl", 20);

    // ---- redirect coincident with ack in FETCH ----
    mem_lat = 0;
    stall   = 1'b0;
    ack_q.push_back(32'h104);
    ack_q.push_back(32'h200);
    instr_q.push_back(exp_instr(32'h200));
    @(negedge clk);
    check("co_req_addr", imem_addr, 32'h104);
    stall       = 1'b1;
    redirect_en = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_en = 1'b0;
    check("co_no_valid", W'(instr_valid), 0);
    check("co_imem_req", W'(imem_req), 1);
    check("co_new_addr", imem_addr, 32'h200);
    @(negedge clk);
    check("co_target_pc", instr_pc, 32'h200);

    // ---- redirect from VALID to the top word, then wrap to 0 ----
    redirect_en = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    ack_q.push_back(32'hFFFF_FFFC);
    instr_q.push_back(exp_instr(32'hFFFF_FFFC));
    ack_q.push_back(32'h0);
    instr_q.push_back(exp_instr(32'h0));
    @(negedge clk);
    redirect_en = 1'b0;
    check("wr_dropped_valid", W'(instr_valid), 0);
    check("wr_top_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    check("wr_top_pc", instr_pc, 32'hFFFF_FFFC);
    stall = 1'b0;
    @(negedge clk);
    check("wr_wrap_addr", imem_addr, 32'h0);
    stall = 1'b1;
    @(negedge clk);

    // ---- misaligned redirect ----
`ifdef FETCH_MISALIGN_CHECK_EN
    mis_tgt = 32'h100;
    mis_exp = 1'b1;
`else
    mis_tgt = 32'h102;
    mis_exp = 1'b0;
`endif
    redirect_en = 1'b1;
    redirect_pc = 32'h102;
    ack_q.push_back(mis_tgt);
    instr_q.push_back(exp_instr(mis_tgt));
    @(negedge clk);
    redirect_en = 1'b0;
    check("mis_req_addr", imem_addr, mis_tgt);
    check("mis_pulse", W'(misalign_err), W'(mis_exp));
    @(negedge clk);
    check("mis_pulse_end", W'(misalign_err), 0);
    check("mis_instr_pc", instr_pc, mis_tgt);

    // ---- drain ----
    repeat (3) @(negedge clk);
    check("ack_queue_left", W'(ack_q.size()), 0);
    check("instr_queue_left", W'(instr_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
